// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity framer.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_framer_acc.sv
// Bit-serial parity accumulator: XORs in each transmitted bit, reloads at frame start.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic init,
  input  logic en,
  input  logic bit_in,
  output logic acc_out
);

  // Load the parity seed on clr, otherwise fold in the bit sent this beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= 1'b0;
    end else if (clr) begin
      acc_out <= init;
    end else if (en) begin
      acc_out <= acc_out ^ bit_in;
    end
  end

endmodule

// File: rtl/serial_parity_framer.sv
// Parallel-to-serial framer: LSB-first data beats followed by one parity beat.
module serial_parity_framer
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic            SEED     = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

  state_t             state;
  logic [DATA_W-1:0]  sreg;
  logic [CNT_W-1:0]   cnt;
  logic               acc;
  logic               load;
  logic               shift_en;

  // Only combinational input-to-output path: ready in IDLE, or as the parity beat leaves.
  assign in_ready = (state == IDLE) || ((state == PARITY) && out_ready);
  assign load     = in_valid && in_ready;
  assign shift_en = (state == SHIFT) && out_ready;

  parity_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (load),
    .init    (SEED),
    .en      (shift_en),
    .bit_in  (sreg[0]),
    .acc_out (acc)
  );

  // Framing FSM with shift register, beat counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, PARITY: begin
          if (load) begin
            state     <= SHIFT;
            sreg      <= in_data;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_bit   <= in_data[0];
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end else if ((state == PARITY) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            sreg <= sreg >> 1;
            if (cnt == LAST_CNT) begin
              // Parity beat carries the accumulator including the bit leaving now.
              state    <= PARITY;
              out_bit  <= acc ^ sreg[0];
              out_last <= 1'b1;
            end else begin
              cnt     <= cnt + CNT_W'(1);
              out_bit <= sreg[1];
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
